// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg                                                              |
// | Shared size encodings, FSM states and lane helpers for the LSU.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LANE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD     = 3'd1,
    S_ST     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_FIN    = 3'd5
  } lsu_state_t;

  // Big-endian lanes: offset 0 is the most significant byte/half.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
    logic [4:0] sh;
    sh = 5'd0;
    if (size == SZ_BYTE)
      sh = {~offset, 3'b000};
    else if (size == SZ_HALF)
      sh = {~offset[1], 4'b0000};
    return sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +----------------------------------------------------------------------+
// | lsu_lane_align                                                       |
// | Load lane extraction/extension and sub-word store merge.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] merge_word,
  input  logic [15:0] store_lo,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  always_comb begin
    w_shift = lane_shift(size, offset);
    w_byte  = rdata[w_shift +: LANE_W];
    w_half  = rdata[w_shift +: HALF_W];
    case (size)
      SZ_BYTE: begin
        load_value = {{24{sign_ext & w_byte[7]}}, w_byte};
        w_mask     = 32'h0000_00FF << w_shift;
        w_ins      = {24'h0, store_lo[7:0]} << w_shift;
      end
      SZ_HALF: begin
        load_value = {{16{sign_ext & w_half[15]}}, w_half};
        w_mask     = 32'h0000_FFFF << w_shift;
        w_ins      = {16'h0, store_lo} << w_shift;
      end
      default: begin
        load_value = rdata;
        w_mask     = 32'h0;
        w_ins      = 32'h0;
      end
    endcase
    merged_word = (merge_word & ~w_mask) | w_ins;
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit                                                      |
// | Byte/half/word loads and stores onto a word-addressed memory.        |
// | Option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_sign;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_merge;
  logic [DATA_W-1:0] r_load_data;

  logic              w_is_load;
  logic              w_conflict;
  logic              w_half;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_addr_in;
  logic [DATA_W-1:0] w_load_value;
  logic [DATA_W-1:0] w_merged;

  assign w_is_load  = mem_read_in & ~mem_write_in;
  assign w_conflict = ~(mem_read_in ^ mem_write_in);
  assign w_half     = (size == SZ_HALF);

`ifdef LSU_MISALIGN_TRAP_EN
  // size[1] covers both the word and the reserved encoding.
  assign w_misalign = (w_half & address[0]) | (size[1] & (|address[1:0]));
  assign w_addr_in  = address;
`else
  assign w_misalign = 1'b0;
  assign w_addr_in  = {address[ADDR_W-1:2],
                       size[1] ? 2'b00 : (w_half ? {address[1], 1'b0} : address[1:0])};
`endif

  lsu_lane_align u_align (
    .size        (r_size),
    .sign_ext    (r_sign),
    .offset      (r_addr[1:0]),
    .rdata       (mem_rdata),
    .merge_word  (r_merge),
    .store_lo    (r_wdata[15:0]),
    .load_value  (w_load_value),
    .merged_word (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_size      <= 2'b00;
      r_sign      <= 1'b0;
      r_err       <= 1'b0;
      r_wdata     <= '0;
      r_merge     <= '0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= w_addr_in;
            r_size  <= size;
            r_sign  <= sign_ext;
            r_wdata <= store_data;
            r_err   <= w_conflict | w_misalign;
            if (w_conflict | w_misalign)
              r_state <= S_FIN;
            else if (w_is_load)
              r_state <= S_LD;
            else if (size[1])
              r_state <= S_ST;
            else
              r_state <= S_RMW_RD;
          end
        end
        S_LD: begin
          r_load_data <= w_load_value;
          r_state     <= S_FIN;
        end
        S_ST:     r_state <= S_FIN;
        S_RMW_RD: begin
          r_merge <= mem_rdata;
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: r_state <= S_FIN;
        S_FIN:    r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Memory strobes come purely from the state register, so an async reset
  // removes them within the same cycle.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    busy        = ~req_ready;
    mem_read    = (r_state == S_LD) || (r_state == S_RMW_RD);
    mem_write   = (r_state == S_ST) || (r_state == S_RMW_WR);
    mem_address = {r_addr[ADDR_W-1:2], 2'b00};
    mem_wdata   = '0;
    if (r_state == S_ST)
      mem_wdata = r_wdata;
    else if (r_state == S_RMW_WR)
      mem_wdata = w_merged;
    done        = (r_state == S_FIN);
    err         = (r_state == S_FIN) & r_err;
    load_data   = r_load_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------+
// | tb_load_store_unit                                                   |
// | Directed vector bench for load_store_unit with a 256x32 memory.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic        mem_read_in, mem_write_in;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] address, store_data, load_data;
  logic        done, err, busy;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .size(size), .sign_ext(sign_ext),
    .address(address), .store_data(store_data),
    .load_data(load_data), .done(done), .err(err), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:255];
  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_wdata;
  assign mem_rdata = mem_read ? mem[mem_address[9:2]] : 32'h0;

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wdata = mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        er;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] ewd;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz, logic sx, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] ld, logic er, int lat,
                              int nrd, int nwr, logic [31:0] ewd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sx = sx; v.addr = addr; v.wdata = wdata;
    v.ld = ld; v.er = er; v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.ewd = ewd;
    return v;
  endfunction

  // Request is held through busy; latency counts clock edges from accept to done.
  task automatic run_vec(input vec_t v, input int idx);
    int   rd0, wr0, lat;
    logic seen, err_at;
    @(negedge clk);
    check("ready", idx, {31'b0, req_ready}, 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    mem_read_in = v.rd; mem_write_in = v.wr; size = v.sz; sign_ext = v.sx;
    address = v.addr; store_data = v.wdata; req_valid = 1'b1;
    lat = 0; seen = 1'b0; err_at = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        err_at = err;
      end
    end
    req_valid = 1'b0;
    check("latency", idx, lat, v.lat);
    check("err", idx, {31'b0, err_at}, {31'b0, v.er});
    check("load_data", idx, load_data, v.ld);
    check("reads", idx, rd_cnt - rd0, v.nrd);
    check("writes", idx, wr_cnt - wr0, v.nwr);
    if (v.nwr > 0) check("wdata", idx, last_wdata, v.ewd);
  endtask

  vec_t        vecs [20];
  logic [31:0] ld13;
  int          wr0, lat;

  initial begin
    reset = 1'b1; req_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    size = 2'b00; sign_ext = 1'b0; address = 32'h0; store_data = 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
    ld13 = 32'hFFFFFFFF;
    vecs[14] = mk(1,0,2'b10,0,32'h23,32'h0,ld13,1,1,0,0,32'h0);
`else
    ld13 = 32'h80FFBEEF;
    vecs[14] = mk(1,0,2'b10,0,32'h23,32'h0,ld13,0,2,1,0,32'h0);
`endif
    vecs[0]  = mk(0,1,2'b10,0,32'h10,32'hDEADBEEF,32'h0,0,2,0,1,32'hDEADBEEF);
    vecs[1]  = mk(1,0,2'b10,0,32'h10,32'h0,32'hDEADBEEF,0,2,1,0,32'h0);
    vecs[2]  = mk(0,1,2'b10,0,32'h10,32'h11223344,32'hDEADBEEF,0,2,0,1,32'h11223344);
    vecs[3]  = mk(0,1,2'b00,0,32'h11,32'h123456AA,32'hDEADBEEF,0,3,1,1,32'h11AA3344);
    vecs[4]  = mk(1,0,2'b10,0,32'h10,32'h0,32'h11AA3344,0,2,1,0,32'h0);
    vecs[5]  = mk(0,1,2'b10,0,32'h20,32'h80FF7F01,32'h11AA3344,0,2,0,1,32'h80FF7F01);
    vecs[6]  = mk(1,0,2'b00,1,32'h20,32'h0,32'hFFFFFF80,0,2,1,0,32'h0);
    vecs[7]  = mk(1,0,2'b00,0,32'h20,32'h0,32'h00000080,0,2,1,0,32'h0);
    vecs[8]  = mk(1,0,2'b01,1,32'h22,32'h0,32'h00007F01,0,2,1,0,32'h0);
    vecs[9]  = mk(1,0,2'b01,1,32'h20,32'h0,32'hFFFF80FF,0,2,1,0,32'h0);
    vecs[10] = mk(1,0,2'b01,0,32'h20,32'h0,32'h000080FF,0,2,1,0,32'h0);
    vecs[11] = mk(1,0,2'b00,1,32'h23,32'h0,32'h00000001,0,2,1,0,32'h0);
    vecs[12] = mk(1,0,2'b00,1,32'h21,32'h0,32'hFFFFFFFF,0,2,1,0,32'h0);
    vecs[13] = mk(0,1,2'b01,0,32'h22,32'h0000BEEF,32'hFFFFFFFF,0,3,1,1,32'h80FFBEEF);
    vecs[15] = mk(1,1,2'b10,0,32'h10,32'h0,ld13,1,1,0,0,32'h0);
    vecs[16] = mk(0,0,2'b10,0,32'h10,32'h0,ld13,1,1,0,0,32'h0);
    vecs[17] = mk(0,1,2'b00,0,32'h13,32'h00000055,ld13,0,3,1,1,32'h11AA3355);
    vecs[18] = mk(1,0,2'b10,0,32'h10,32'h0,32'h11AA3355,0,2,1,0,32'h0);
    vecs[19] = mk(1,0,2'b11,1,32'h10,32'h0,32'h11AA3355,0,2,1,0,32'h0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 0, {31'b0, req_ready}, 32'd1);
    check("rst_busy", 0, {31'b0, busy}, 32'd0);
    check("rst_done_err", 0, {30'b0, done, err}, 32'd0);
    check("rst_mem_rw", 0, {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_load_data", 0, load_data, 32'h0);
    check("rst_mem_address", 0, mem_address, 32'h0);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Reset while in RMW_RD: the write must never happen.
    @(negedge clk);
    wr0 = wr_cnt;
    mem_read_in = 1'b0; mem_write_in = 1'b1; size = 2'b00; sign_ext = 1'b0;
    address = 32'h10; store_data = 32'h77; req_valid = 1'b1;
    @(negedge clk);
    check("rmw_rd_read", 100, {31'b0, mem_read}, 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    #1;
    check("rst_async_write", 100, {31'b0, mem_write}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 100, {31'b0, req_ready}, 32'd1);
    check("rst_mid_writes", 100, wr_cnt - wr0, 32'd0);
    check("rst_mid_mem", 100, mem[4], 32'h11AA3355);
    check("rst_mid_load_data", 100, load_data, 32'h0);

    // Back-to-back: keep req_valid high across done and expect accept in first IDLE cycle.
    @(negedge clk);
    mem_read_in = 1'b1; mem_write_in = 1'b0; size = 2'b10; sign_ext = 1'b0;
    address = 32'h20; req_valid = 1'b1;
    lat = 0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_lat", 101, lat, 32'd2);
    check("b2b_first_data", 101, load_data, ld13 == 32'hFFFFFFFF ? 32'h80FFBEEF : ld13);
    address = 32'h10;
    @(negedge clk);
    check("b2b_idle_ready", 101, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("b2b_accepted_busy", 101, {31'b0, busy}, 32'd1);
    check("b2b_accepted_read", 101, {31'b0, mem_read}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_done", 101, {31'b0, done}, 32'd1);
    check("b2b_second_data", 101, load_data, 32'h11AA3355);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory (256 x 32-bit, combinational read, synchronous write).
- Converts CPU byte, halfword and word loads/stores into whole-word memory accesses.
- Sub-word stores use a read-modify-write sequence; sub-word loads use lane extraction with sign or zero extension.
- Multi-cycle; asserts busy so control can stall the PC.

Parameters:
- ADDR_W, 32, width of CPU and memory addresses.
- DATA_W, 32, data word width; fixed at 32, since lane logic assumes 4 bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request from execute stage.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- mem_read_in  in  1  request is a load.
- mem_write_in  in  1  request is a store.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- sign_ext  in  1  sign-extend sub-word loads (lb/lh) versus zero-extend (lbu/lhu).
- address  in  ADDR_W  byte address.
- store_data  in  DATA_W  store value, right-aligned.
- load_data  out  DATA_W  extended load result.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- busy  out  1  equals !req_ready.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_address  out  ADDR_W  word-aligned (bits [1:0] = 00).
- mem_wdata  out  DATA_W  merged write word.
- mem_rdata  in  DATA_W  data memory readData (0 when mem_read low).

Behaviour:
- Reset state: FSM in IDLE, all outputs 0, load_data 0, latched request registers 0.
- Memory outputs decode from current state only, so reset mid-operation drops mem_write immediately and no partial write occurs.
- Byte lanes are big-endian:
  - Byte offset 0 maps to bits [31:24], offset 3 to [7:0].
  - Half offset 0 maps to [31:16], offset 2 to [15:0].
- FSM states: IDLE, LD, ST, RMW_RD, RMW_WR, FIN.
- IDLE, on accept:
  - Latch address, size, sign_ext and store_data.
  - If both mem_read_in and mem_write_in are high, or both are low: go to FIN with err=1 and no memory access.
  - Load goes to LD; word store goes to ST; byte/half store goes to RMW_RD.
- LD: mem_read=1. Capture the extracted and extended lane into load_data at the clock edge. Go to FIN.
- ST: mem_write=1, mem_wdata = store_data. Go to FIN.
- RMW_RD: mem_read=1. Capture mem_rdata into merge register. Go to RMW_WR.
- RMW_WR: mem_write=1. mem_wdata = merge register with the addressed lane replaced by store_data[7:0] or [15:0]. Go to FIN.
- FIN: done=1, err as latched. Go to IDLE.
- Latency from accept edge to done: load 2, word store 2, sub-word store 3.
- load_data holds its value until the next successful load; it is unchanged on stores and errors.
- req_valid during busy is ignored; upstream must hold the request until req_ready.
- Back-to-back requests are allowed: a new request is accepted in the first IDLE cycle after FIN.
- mem_address is held stable throughout each state and is never driven to X.
- Address bits above [9:2] pass through unchanged; memory wrap is the memory's concern.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: half access with address[0]=1, or word access with address[1:0]!=00, goes IDLE->FIN with err=1. No memory access occurs and load_data is unchanged.
- Not defined: low address bits are forced to alignment (half clears bit 0, word clears bits 1:0) and the access proceeds normally. err is then raised only for read/write conflicts.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - lane-index helper constants.
- One combinational sub-module, lsu_lane_align, performs load extraction/extension and store merge. The FSM stays in the top module.

Test Plan:
- Word store then load: store 0xDEADBEEF at address 0x10, then load word 0x10 -> mem_write for one cycle with mem_wdata 0xDEADBEEF; load_data=0xDEADBEEF; done 2 cycles after each accept.
- Sub-word store RMW: memory word at 0x10 = 0x11223344; sb 0xAA to address 0x11 -> RMW_RD then RMW_WR with mem_wdata=0x11AA3344; done 3 cycles after accept.
- Load extension: word 0x80FF7F01 at 0x20:
  - lb 0x20 -> 0xFFFFFF80;
  - lbu 0x20 -> 0x00000080;
  - lh 0x22 -> 0x00007F01;
  - lh 0x20 -> 0xFFFF80FF.
- Misalign: lw 0x23 -> with macro defined, err=1, no mem_read, load_data unchanged; without the macro, the word at 0x20 is returned and err=0.
- Reset mid-RMW: assert reset during RMW_RD -> mem_write never pulses, memory word unchanged, req_ready=1 after release.
- Conflict and busy: request with both read and write set -> done+err, no memory access; req_valid held during busy -> only one access performed.
